// File: rtl/ser_pkg.sv
// Framing definitions shared by the serializer and the deframer so both ends
// agree on start/stop/idle levels and on the receive FSM encoding.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/ser_shift_in.sv
// Right-shifting receive register: new bits enter at the MSB, so after WIDTH
// shifts of an LSB-first stream bit 0 holds the first bit received.
module ser_shift_in #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shreg_q;

  always_comb begin
    shreg_d = shreg_q;
    if (shift_en) begin
      shreg_d = {serial_in, shreg_q[WIDTH-1:1]};
    end else begin
      shreg_d = shreg_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign parallel_out = shreg_q;

endmodule

// File: rtl/ser_deframer.sv
// Serial frame receiver: start bit, word_size LSB-first data bits, stop bit,
// delivered through a one-entry valid/ready buffer with error/overrun flags.
module ser_deframer
  import ser_pkg::*;
#(
  parameter int unsigned word_size = 4,
  parameter int unsigned CNT_W     = $clog2(word_size)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Data_in,
  output logic [word_size-1:0] Data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(word_size - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e               state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [word_size-1:0] data_d, data_q;
  logic                 valid_d, valid_q;
  logic                 ferr_d, ferr_q;
  logic                 ovr_d, ovr_q;
  logic                 shift_en;
  logic [word_size-1:0] shreg;

  ser_shift_in #(.WIDTH(word_size)) u_shift_in (
    .clock        (clock),
    .reset        (reset),
    .shift_en     (shift_en),
    .serial_in    (Data_in),
    .parallel_out (shreg)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    ferr_d   = 1'b0;
    ovr_d    = ovr_q;
    shift_en = 1'b0;
    // Consumption first; a load in STOP below overrides it on the same edge.
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      IDLE: begin
        if (Data_in == START_BIT) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          state_d = SHIFT;
        end
      end
      STOP: begin
        state_d = IDLE;
        if (Data_in != STOP_BIT) begin
          ferr_d = 1'b1;
        end else if (!valid_q || out_ready) begin
          data_d  = shreg;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Data_out  = data_q;
  assign out_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_ser_deframer.sv
// Randomized and directed frame stimulus with a frame-level reference model;
// a negedge monitor checks outputs and pops the word scoreboard on handshakes.
module tb_ser_deframer;

  localparam int WS = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          Data_in = 1'b0;
  logic          out_ready = 1'b0;
  logic [WS-1:0] Data_out;
  logic          out_valid;
  logic          frame_err;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WS-1:0] exp_q[$];
  logic          m_valid = 1'b0;
  logic [WS-1:0] m_data  = '0;
  logic          m_ferr  = 1'b0;
  logic          m_ovr   = 1'b0;
  bit            running = 1'b0;

  ser_deframer #(.word_size(WS)) dut (
    .clock     (clock),
    .reset     (reset),
    .Data_in   (Data_in),
    .Data_out  (Data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; after the edge the reference model applies the
  // frame rules knowing whether this bit was a frame's stop bit.
  task automatic step(input logic din, input logic rdy, input logic is_stop, input logic [WS-1:0] w);
    logic hs, ld;
    Data_in   = din;
    out_ready = rdy;
    @(posedge clock);
    #1;
    hs     = m_valid && rdy;
    ld     = is_stop && !din && (!m_valid || rdy);
    m_ferr = is_stop && din;
    if (is_stop && !din && !ld) m_ovr = 1'b1;
    if (ld) begin
      m_valid = 1'b1;
      m_data  = w;
      exp_q.push_back(w);
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    Data_in   = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    m_valid = 1'b0;
    m_data  = '0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    exp_q.delete();
    reset = 1'b0;
  endtask

  // mode: 0 ready low, 1 ready high, 2 random ready, 3 ready only on the stop bit
  task automatic send_frame(input logic [WS-1:0] w, input logic stop_val, input int mode, input int gap);
    logic r;
    for (int c = 0; c < WS + 2 + gap; c++) begin
      case (mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        2:       r = 1'($urandom_range(0, 1));
        default: r = (c == WS + 1);
      endcase
      if (c == 0)           step(1'b1, r, 1'b0, w);
      else if (c <= WS)     step(w[c-1], r, 1'b0, w);
      else if (c == WS + 1) step(stop_val, r, 1'b1, w);
      else                  step(1'b0, r, 1'b0, w);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, '0);
  endtask

  always @(negedge clock) begin
    if (running) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("Data_out", 32'(Data_out), 32'(m_data));
      check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 32'd0, 32'd1);
        end else begin
          check("sb_word", 32'(Data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    do_reset();
    running = 1'b1;
    idle(2, 1'b0);

    // Reset in the middle of a frame, then an idle line.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    do_reset();
    idle(8, 1'b0);

    // Single frame held, then consumed.
    send_frame(4'h5, 1'b0, 0, 0);
    check("single_word", 32'(Data_out), 32'h5);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0);
    idle(2, 1'b0);

    // Back-to-back frames with ready held high.
    send_frame(4'hA, 1'b0, 1, 0);
    send_frame(4'h3, 1'b0, 1, 0);
    idle(2, 1'b1);

    // Overrun: second frame arrives while the buffer is full.
    send_frame(4'h5, 1'b0, 0, 0);
    send_frame(4'hF, 1'b0, 0, 0);
    idle(3, 1'b1);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    do_reset();
    idle(2, 1'b0);

    // Framing error followed by a good frame.
    send_frame(4'h6, 1'b1, 0, 0);
    send_frame(4'h6, 1'b0, 0, 0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Accept and load on the same edge.
    send_frame(4'h5, 1'b0, 0, 0);
    send_frame(4'h9, 1'b0, 3, 0);
    check("simul_word", 32'(Data_out), 32'h9);
    idle(2, 1'b1);
    do_reset();

    // Random frames, gaps, stop errors and consumer readiness.
    for (int f = 0; f < 150; f++) begin
      send_frame(WS'($urandom), ($urandom_range(0, 9) == 0), 2, int'($urandom_range(0, 2)));
    end
    idle(4, 1'b1);

    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
